// File: rtl/frame_scheduler.sv
`timescale 1ns/1ps
// Frame-synchronous game sequencer: owns the game FSM, issues game ticks at frame start, and keeps score/speed.
// Define NIGHT_CYCLE_EN to enable the day/night palette toggle every NIGHT_STEP points.
module frame_scheduler #(
    parameter int BASE_PERIOD  = 6,
    parameter int SPEED_MAX    = 4,
    parameter int SCORE_STEP   = 100,
    parameter int SCORE_MAX    = 9999,
    parameter int DEATH_FRAMES = 30,
    parameter int NIGHT_STEP   = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vs,
    input  logic        start,
    input  logic        jump,
    input  logic        collision,
    output logic        game_tick,
    output logic [1:0]  state,
    output logic [13:0] score,
    output logic [2:0]  speed,
    output logic        freeze,
    output logic        night
);

    localparam int CNT_MAX = (BASE_PERIOD > DEATH_FRAMES) ? BASE_PERIOD : DEATH_FRAMES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int SW      = $clog2(SCORE_STEP + 1);

    if (BASE_PERIOD <= SPEED_MAX || NIGHT_STEP < 1) begin : g_bad_cfg
        $error("frame_scheduler: BASE_PERIOD must exceed SPEED_MAX and NIGHT_STEP must be positive");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        DYING   = 2'd2,
        OVER    = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic            vs_q, start_q, jump_q;
    logic [CW-1:0]   frame_cnt_q, frame_cnt_d;
    logic [SW-1:0]   step_cnt_q, step_cnt_d;
    logic [13:0]     score_q, score_d;
    logic [2:0]      speed_q, speed_d;
    logic            tick_q, tick_d;
    logic            freeze_q;

    logic            frame_start, start_rise, jump_rise;
    logic            restart, tick_due, advance;
    logic [CW-1:0]   tick_last;

    assign frame_start = vs_q & ~vs;
    assign start_rise  = start & ~start_q;
    assign jump_rise   = jump & ~jump_q;
    assign tick_last   = CW'(BASE_PERIOD - 1) - CW'(speed_q);

    assign restart  = ((state_q == IDLE) || (state_q == OVER)) && (start_rise || jump_rise);
    // Collision outranks a due tick, so a fatal frame never scores.
    assign tick_due = (state_q == RUNNING) && !collision && frame_start && (frame_cnt_q == tick_last);
    assign advance  = tick_due && (score_q != 14'(SCORE_MAX));

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        step_cnt_d  = step_cnt_q;
        score_d     = score_q;
        speed_d     = speed_q;
        tick_d      = 1'b0;
        case (state_q)
            IDLE, OVER: begin
                if (restart) begin
                    state_d     = RUNNING;
                    frame_cnt_d = '0;
                    step_cnt_d  = '0;
                    score_d     = '0;
                    speed_d     = '0;
                end
            end
            RUNNING: begin
                if (collision) begin
                    state_d     = DYING;
                    frame_cnt_d = '0;
                end else if (frame_start) begin
                    if (tick_due) begin
                        tick_d      = 1'b1;
                        frame_cnt_d = '0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + CW'(1);
                    end
                end
                if (advance) begin
                    score_d = score_q + 14'd1;
                    if (step_cnt_q == SW'(SCORE_STEP - 1)) begin
                        step_cnt_d = '0;
                        if (speed_q < 3'(SPEED_MAX)) begin
                            speed_d = speed_q + 3'd1;
                        end
                    end else begin
                        step_cnt_d = step_cnt_q + SW'(1);
                    end
                end
            end
            DYING: begin
                if (frame_start) begin
                    if (frame_cnt_q == CW'(DEATH_FRAMES - 1)) begin
                        state_d     = OVER;
                        frame_cnt_d = '0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Edge-detect copies always track their inputs, so levels held through reset never look like edges.
    always_ff @(posedge clk) begin
        vs_q    <= vs;
        start_q <= start;
        jump_q  <= jump;
        if (rst) begin
            state_q     <= IDLE;
            frame_cnt_q <= '0;
            step_cnt_q  <= '0;
            score_q     <= '0;
            speed_q     <= '0;
            tick_q      <= 1'b0;
            freeze_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            step_cnt_q  <= step_cnt_d;
            score_q     <= score_d;
            speed_q     <= speed_d;
            tick_q      <= tick_d;
            freeze_q    <= (state_d != RUNNING);
        end
    end

`ifdef NIGHT_CYCLE_EN
    localparam int NW = $clog2(NIGHT_STEP + 1);

    logic [NW-1:0] night_cnt_q, night_cnt_d;
    logic          night_q, night_d;

    always_comb begin
        night_cnt_d = night_cnt_q;
        night_d     = night_q;
        if (restart) begin
            night_cnt_d = '0;
            night_d     = 1'b0;
        end else if (advance) begin
            if (night_cnt_q == NW'(NIGHT_STEP - 1)) begin
                night_cnt_d = '0;
                night_d     = ~night_q;
            end else begin
                night_cnt_d = night_cnt_q + NW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            night_cnt_q <= '0;
            night_q     <= 1'b0;
        end else begin
            night_cnt_q <= night_cnt_d;
            night_q     <= night_d;
        end
    end

    assign night = night_q;
`else
    assign night = 1'b0;
`endif

    assign game_tick = tick_q;
    assign state     = state_q;
    assign score     = score_q;
    assign speed     = speed_q;
    assign freeze    = freeze_q;

endmodule
